// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - RV32I fetch stage: program counter, IF/ID register, load-use hazard detect
//
// Purpose:
//   Owns the program counter and presents it to an asynchronous instruction ROM.
//   The fetched word is registered into the IF/ID pipeline register. Branch redirects
//   from EX flush the IF/ID register. Load-use hazards against the ID/EX register
//   freeze fetch for one cycle and request a bubble into ID/EX.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr / imem_rdata   instruction ROM address (current pc) and same-cycle data
//   branch_taken/_target     redirect request from EX (target forced word aligned)
//   ext_stall                external freeze of pc and IF/ID
//   IDEX_MemoryRead, IDEX_rd load flag and destination held in ID/EX
//   IFID_pc, IFID_pc_plus4   pc of the registered instruction and pc+4
//   IFID_instr, IFID_valid   registered instruction and its valid flag
//   IFID_rs1/rs2/rd          register fields sliced from IFID_instr
//   hazard_stall             load-use stall (combinational)
//   IDEX_bubble              ID/EX loads zero controls on the next edge (combinational)
//
// Optional feature macro: HAZARD_DETECT_EN enables load-use detection; when undefined
// hazard_stall is tied low and the IDEX_* inputs are ignored.

module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ext_stall,
  input  logic        IDEX_MemoryRead,
  input  logic [4:0]  IDEX_rd,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_pc_plus4,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid,
  output logic [4:0]  IFID_rs1,
  output logic [4:0]  IFID_rs2,
  output logic [4:0]  IFID_rd,
  output logic        hazard_stall,
  output logic        IDEX_bubble
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Natural 32-bit wrap: 32'hFFFF_FFFC advances to 0.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  assign IFID_rs1 = IFID_instr[19:15];
  assign IFID_rs2 = IFID_instr[24:20];
  assign IFID_rd  = IFID_instr[11:7];

  // Redirect targets are forced to word alignment, so the low two bits never matter.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

`ifdef HAZARD_DETECT_EN
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0] opcode;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       rs1_match;
  logic       rs2_match;

  assign opcode = IFID_instr[6:0];

  // U-type and JAL carry immediate bits in the rs1 field; only R, S and B
  // formats actually read rs2.
  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign rs1_match = uses_rs1 && (IDEX_rd == IFID_rs1);
  assign rs2_match = uses_rs2 && (IDEX_rd == IFID_rs2);

  // x0 is never a real dependency, and a squashed IF/ID slot has no sources.
  assign hazard_stall = IFID_valid && IDEX_MemoryRead && (IDEX_rd != 5'd0)
                        && (rs1_match || rs2_match);
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = IDEX_MemoryRead ^ (^IDEX_rd);
  assign hazard_stall = 1'b0;
`endif

  // ext_stall is deliberately absent: ID/EX freezes alongside IF/ID in that case.
  assign IDEX_bubble = hazard_stall || branch_taken || !IFID_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      IFID_pc       <= 32'd0;
      IFID_pc_plus4 <= 32'd0;
      IFID_instr    <= NOP_INSTR;
      IFID_valid    <= 1'b0;
    end else if (branch_taken) begin
      // Redirect beats any stall; the wrong-path fetch is squashed in IF/ID.
      pc            <= {branch_target[31:2], 2'b00};
      IFID_pc       <= 32'd0;
      IFID_pc_plus4 <= 32'd0;
      IFID_instr    <= NOP_INSTR;
      IFID_valid    <= 1'b0;
    end else if (!(hazard_stall || ext_stall)) begin
      pc            <= pc_plus4;
      IFID_pc       <= pc;
      IFID_pc_plus4 <= pc_plus4;
      IFID_instr    <= imem_rdata;
      IFID_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage: vector table, hazard sequences, random vs model
module tb_if_id_stage;

`ifdef HAZARD_DETECT_EN
  localparam bit HZ_ON = 1'b1;
`else
  localparam bit HZ_ON = 1'b0;
`endif

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADD_W   = 32'h0062_81B3; // add x3,x5,x6
  localparam logic [31:0] LUI_W   = 32'h0002_82B7; // lui x5 with rs1 field = 5

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ext_stall;
  logic        IDEX_MemoryRead;
  logic [4:0]  IDEX_rd;
  logic [31:0] IFID_pc;
  logic [31:0] IFID_pc_plus4;
  logic [31:0] IFID_instr;
  logic        IFID_valid;
  logic [4:0]  IFID_rs1;
  logic [4:0]  IFID_rs2;
  logic [4:0]  IFID_rd;
  logic        hazard_stall;
  logic        IDEX_bubble;

  logic [31:0] rom [64];
  assign imem_rdata = rom[imem_addr[7:2]];

  if_id_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .ext_stall(ext_stall),
    .IDEX_MemoryRead(IDEX_MemoryRead), .IDEX_rd(IDEX_rd),
    .IFID_pc(IFID_pc), .IFID_pc_plus4(IFID_pc_plus4), .IFID_instr(IFID_instr),
    .IFID_valid(IFID_valid), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2), .IFID_rd(IFID_rd),
    .hazard_stall(hazard_stall), .IDEX_bubble(IDEX_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_ip4, m_instr;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Load-use rule from the instruction format: which fields are real sources.
  function automatic logic model_hz(input logic [31:0] ins, input logic v,
                                    input logic m, input logic [4:0] r);
    logic [6:0] op;
    logic u1, u2;
    op = ins[6:0];
    u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return HZ_ON && v && m && (r != 5'd0) &&
           ((u1 && r == ins[19:15]) || (u2 && r == ins[24:20]));
  endfunction

  // Advance the model by one edge using the current inputs, then step the clock.
  task automatic tick();
    logic hz;
    hz = model_hz(m_instr, m_valid, IDEX_MemoryRead, IDEX_rd);
    if (rst) begin
      m_pc = 32'h0; m_ipc = 0; m_ip4 = 0; m_instr = NOP; m_valid = 0;
    end else if (branch_taken) begin
      m_pc = branch_target & ~32'd3; m_ipc = 0; m_ip4 = 0; m_instr = NOP; m_valid = 0;
    end else if (!(hz || ext_stall)) begin
      m_instr = rom[m_pc[7:2]];
      m_ipc   = m_pc;
      m_pc    = m_pc + 32'd4;
      m_ip4   = m_pc;
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic hz;
    hz = model_hz(m_instr, m_valid, IDEX_MemoryRead, IDEX_rd);
    chk("rnd_pc",     imem_addr,     m_pc);
    chk("rnd_ifpc",   IFID_pc,       m_ipc);
    chk("rnd_ifpc4",  IFID_pc_plus4, m_ip4);
    chk("rnd_instr",  IFID_instr,    m_instr);
    chk("rnd_valid",  {31'd0, IFID_valid}, {31'd0, m_valid});
    chk("rnd_rs1",    {27'd0, IFID_rs1}, {27'd0, m_instr[19:15]});
    chk("rnd_rs2",    {27'd0, IFID_rs2}, {27'd0, m_instr[24:20]});
    chk("rnd_rd",     {27'd0, IFID_rd},  {27'd0, m_instr[11:7]});
    chk("rnd_hazard", {31'd0, hazard_stall}, {31'd0, hz});
    chk("rnd_bubble", {31'd0, IDEX_bubble},
        {31'd0, hz || branch_taken || !m_valid});
  endtask

  task automatic drive(input logic r, input logic bt, input logic [31:0] tgt,
                       input logic st, input logic mr, input logic [4:0] rd);
    rst = r; branch_taken = bt; branch_target = tgt; ext_stall = st;
    IDEX_MemoryRead = mr; IDEX_rd = rd;
  endtask

  typedef struct {
    logic        rst, bt;
    logic [31:0] tgt;
    logic        stall;
    logic [31:0] e_pc, e_ipc, e_ip4, e_instr;
    logic        e_valid, e_bub;
  } vec_t;

  vec_t tbl [13];

  logic [6:0] ops [8];

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'(i + 1);
    rom[8] = ADD_W;
    rom[9] = LUI_W;

    //           rst bt  tgt           st  pc            ipc           ip4      instr  v  bub
    tbl[0]  = '{0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,  NOP,   0, 1};
    tbl[1]  = '{0, 0, 32'h0,        0, 32'h4,        32'h0,        32'h4,  32'd1, 1, 0};
    tbl[2]  = '{0, 0, 32'h0,        0, 32'h8,        32'h4,        32'h8,  32'd2, 1, 0};
    tbl[3]  = '{0, 0, 32'h0,        0, 32'hC,        32'h8,        32'hC,  32'd3, 1, 0};
    tbl[4]  = '{0, 0, 32'h0,        1, 32'h10,       32'hC,        32'h10, 32'd4, 1, 0};
    tbl[5]  = '{0, 0, 32'h0,        1, 32'h10,       32'hC,        32'h10, 32'd4, 1, 0};
    tbl[6]  = '{0, 0, 32'h0,        1, 32'h10,       32'hC,        32'h10, 32'd4, 1, 0};
    tbl[7]  = '{0, 0, 32'h0,        0, 32'h10,       32'hC,        32'h10, 32'd4, 1, 0};
    tbl[8]  = '{0, 1, 32'h103,      0, 32'h14,       32'h10,       32'h14, 32'd5, 1, 1};
    tbl[9]  = '{0, 1, 32'hFFFFFFFF, 0, 32'h100,      32'h0,        32'h0,  NOP,   0, 1};
    tbl[10] = '{0, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h0,        32'h0,  NOP,   0, 1};
    tbl[11] = '{1, 1, 32'h40,       1, 32'h0,        32'hFFFFFFFC, 32'h0,  32'd64,1, 1};
    tbl[12] = '{0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,  NOP,   0, 1};

    drive(1, 0, 0, 0, 0, 0);
    m_pc = 0; m_ipc = 0; m_ip4 = 0; m_instr = NOP; m_valid = 0;
    tick();
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].bt, tbl[i].tgt, tbl[i].stall, 0, 0);
      #1;
      chk($sformatf("v%0d_pc", i),     imem_addr,     tbl[i].e_pc);
      chk($sformatf("v%0d_ifpc", i),   IFID_pc,       tbl[i].e_ipc);
      chk($sformatf("v%0d_ifpc4", i),  IFID_pc_plus4, tbl[i].e_ip4);
      chk($sformatf("v%0d_instr", i),  IFID_instr,    tbl[i].e_instr);
      chk($sformatf("v%0d_valid", i),  {31'd0, IFID_valid},  {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_bubble", i), {31'd0, IDEX_bubble}, {31'd0, tbl[i].e_bub});
      chk($sformatf("v%0d_hazard", i), {31'd0, hazard_stall}, 32'd0);
      tick();
    end

    // Load-use against add x3,x5,x6
    drive(0, 1, 32'h20, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);      tick();
    chk("hz_fetch_add", IFID_instr, ADD_W);
    drive(0, 0, 0, 0, 1, 5'd5); #1;
    chk("hz_rs1_stall",  {31'd0, hazard_stall}, {31'd0, HZ_ON});
    chk("hz_rs1_bubble", {31'd0, IDEX_bubble},  {31'd0, HZ_ON});
    drive(0, 0, 0, 0, 1, 5'd0); #1;
    chk("hz_rd0_stall",  {31'd0, hazard_stall}, 32'd0);
    chk("hz_rd0_bubble", {31'd0, IDEX_bubble},  32'd0);
    drive(0, 0, 0, 0, 1, 5'd6); #1;
    chk("hz_rs2_stall",  {31'd0, hazard_stall}, {31'd0, HZ_ON});
    drive(0, 0, 0, 0, 0, 5'd5); #1;
    chk("hz_noload",     {31'd0, hazard_stall}, 32'd0);
    drive(0, 0, 0, 0, 1, 5'd5); tick();
    chk("hz_pc_hold",    imem_addr,  HZ_ON ? 32'h24 : 32'h28);
    chk("hz_instr_hold", IFID_instr, HZ_ON ? ADD_W : LUI_W);
    // Redirect in the same cycle as a hazard: redirect wins
    drive(0, 1, 32'h103, 0, 1, 5'd5); #1;
    chk("br_hz_stall",  {31'd0, hazard_stall}, {31'd0, HZ_ON});
    chk("br_hz_bubble", {31'd0, IDEX_bubble},  32'd1);
    tick();
    chk("br_pc",    imem_addr,  32'h100);
    chk("br_instr", IFID_instr, NOP);
    chk("br_valid", {31'd0, IFID_valid}, 32'd0);

    // lui does not read rs1 even though its immediate bits alias rs1=5
    drive(0, 1, 32'h24, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);      tick();
    chk("lui_fetch", IFID_instr, LUI_W);
    drive(0, 0, 0, 0, 1, 5'd5); #1;
    chk("lui_nostall", {31'd0, hazard_stall}, 32'd0);
    tick();
    chk("lui_advance", imem_addr, 32'h2C);

    // Randomised phase against the reference model
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b0000011, 7'b0010011};
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0]   = ops[$urandom_range(0, 7)];
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      rom[i] = w;
    end
    for (int c = 0; c < 600; c++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, tgt,
            $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)));
      #1;
      check_model();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
